// File: rtl/pipe_sched.sv
// In-order pipeline hazard scheduler: combinational stall/bubble/freeze from EX/MEM/WB write tracking, 0-cycle decision.
// mem_busy freezes every slot and the counter; WB_BYPASS_EN drops the WB slot from the hazard compare.
module pipe_sched (
  input  logic        clk,
  input  logic        rst,
  input  logic        dec_valid,
  input  logic [2:0]  dec_rs,
  input  logic [2:0]  dec_rt,
  input  logic        dec_rs_used,
  input  logic        dec_rt_used,
  input  logic        dec_wr,
  input  logic [2:0]  dec_wr_reg,
  input  logic        mem_busy,
  input  logic        flush,
  output logic        stall_id,
  output logic        bubble_ex,
  output logic        freeze,
  output logic [7:0]  pend_vec,
  output logic [15:0] stall_cnt
);

  typedef struct packed {
    logic       vld;
    logic [2:0] rgn;
  } slot_t;

  slot_t       ex_slot, mem_slot, wb_slot;
  logic [7:0]  ex_oh, mem_oh, wb_oh;
  logic        rs_hit, rt_hit, hit, issue;
  logic [15:0] cnt_nxt;

  // Invalid slots never contribute, whatever their reg field holds.
  always_comb begin
    ex_oh  = ex_slot.vld  ? (8'd1 << ex_slot.rgn)  : 8'd0;
    mem_oh = mem_slot.vld ? (8'd1 << mem_slot.rgn) : 8'd0;
    wb_oh  = wb_slot.vld  ? (8'd1 << wb_slot.rgn)  : 8'd0;
  end

`ifdef WB_BYPASS_EN
  // Register file writes before it is read, so WB never blocks decode.
  assign pend_vec = ex_oh | mem_oh;
  logic unused_wb;
  assign unused_wb = ^wb_oh;
`else
  assign pend_vec = ex_oh | mem_oh | wb_oh;
`endif

  assign rs_hit = dec_rs_used & pend_vec[dec_rs];
  assign rt_hit = dec_rt_used & pend_vec[dec_rt];
  assign hit    = dec_valid & ~flush & (rs_hit | rt_hit);
  assign issue  = dec_valid & ~hit & ~flush;

  assign freeze    = mem_busy;
  assign stall_id  = mem_busy | hit;
  assign bubble_ex = ~mem_busy & (hit | flush | ~dec_valid);

  assign cnt_nxt = (hit && !mem_busy && stall_cnt != 16'hFFFF) ? stall_cnt + 16'd1 : stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_slot   <= '0;
      mem_slot  <= '0;
      wb_slot   <= '0;
      stall_cnt <= 16'd0;
    end else begin
      if (!mem_busy) begin
        wb_slot  <= mem_slot;
        mem_slot <= ex_slot;
        ex_slot  <= issue ? slot_t'{vld: dec_wr, rgn: dec_wr_reg} : '0;
      end
      stall_cnt <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_pipe_sched.sv
// Bench for pipe_sched: directed hazard scenarios plus randomized traffic against a write-history model.
module tb_pipe_sched;

`ifdef WB_BYPASS_EN
  localparam int NSTALL = 2;
`else
  localparam int NSTALL = 3;
`endif

  logic        clk = 1'b0;
  logic        rst, dec_valid, dec_rs_used, dec_rt_used, dec_wr, mem_busy, flush;
  logic [2:0]  dec_rs, dec_rt, dec_wr_reg;
  logic        stall_id, bubble_ex, freeze;
  logic [7:0]  pend_vec;
  logic [15:0] stall_cnt;

  int n_tot = 0;
  int n_bad = 0;
  bit cmp_on = 1'b0;
  bit force_on = 1'b0;

  always #5 clk = ~clk;

  pipe_sched dut (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_rs(dec_rs), .dec_rt(dec_rt),
    .dec_rs_used(dec_rs_used), .dec_rt_used(dec_rt_used), .dec_wr(dec_wr),
    .dec_wr_reg(dec_wr_reg), .mem_busy(mem_busy), .flush(flush),
    .stall_id(stall_id), .bubble_ex(bubble_ex), .freeze(freeze),
    .pend_vec(pend_vec), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: every issued write is remembered with the advance count at which
  // it issued; its age in advancing cycles says which stage it occupies.
  typedef struct {
    int         t;
    logic [2:0] r;
  } wr_t;

  wr_t  hist[$];
  int   m_adv = 0;
  int   m_cnt = 0;
  logic [7:0] m_pend;
  logic m_hit, m_issue;

  always @(negedge clk) begin
    if (cmp_on) begin
      m_pend = 8'h00;
      foreach (hist[i]) begin
        if (m_adv - hist[i].t >= 1 && m_adv - hist[i].t <= NSTALL)
          m_pend[hist[i].r] = 1'b1;
      end
      m_hit   = dec_valid && !flush && ((dec_rs_used && m_pend[dec_rs]) || (dec_rt_used && m_pend[dec_rt]));
      m_issue = dec_valid && !m_hit && !flush;
      chk("cyc_freeze",    32'(freeze),    32'(mem_busy));
      chk("cyc_stall_id",  32'(stall_id),  32'(mem_busy | m_hit));
      chk("cyc_bubble_ex", 32'(bubble_ex), 32'(!mem_busy && (m_hit || flush || !dec_valid)));
      chk("cyc_pend_vec",  32'(pend_vec),  32'(m_pend));
      if (force_on) m_cnt = 32'hFFFE;
      else chk("cyc_stall_cnt", 32'(stall_cnt), 32'(m_cnt));
      if (rst) begin
        hist.delete();
        m_cnt = 0;
      end else if (!mem_busy) begin
        if (m_issue && dec_wr) hist.push_back('{t: m_adv, r: dec_wr_reg});
        m_adv++;
        if (m_hit && m_cnt < 16'hFFFF) m_cnt++;
        while (hist.size() > 0 && m_adv - hist[0].t > 3) void'(hist.pop_front());
      end
    end
  end

  task automatic drive(input logic v, input logic [2:0] rs, input logic rsu, input logic [2:0] rt,
                       input logic rtu, input logic w, input logic [2:0] wr, input logic mb,
                       input logic fl, input logic r);
    dec_valid = v; dec_rs = rs; dec_rs_used = rsu; dec_rt = rt; dec_rt_used = rtu;
    dec_wr = w; dec_wr_reg = wr; mem_busy = mb; flush = fl; rst = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end
  endtask

  task automatic wr_reg(input logic [2:0] r);
    drive(1, 0, 0, 0, 0, 1, r, 0, 0, 0);
    tick();
  endtask

  task automatic rd_reg(input logic [2:0] r, input logic mb, input logic fl, input logic rs_t);
    drive(1, r, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, mb, fl, rs_t);
  endtask

  int base;

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    cmp_on = 1'b1;
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("rst_cnt",    32'(stall_cnt), 32'd0);
    chk("rst_pend",   32'(pend_vec),  32'd0);
    chk("rst_stall",  32'(stall_id),  32'd0);
    chk("rst_bubble", 32'(bubble_ex), 32'd1);
    chk("rst_freeze", 32'(freeze),    32'd0);
    tick();

    // Back-to-back RAW on R3.
    wr_reg(3'd3);
    for (int i = 0; i < NSTALL; i++) begin
      rd_reg(3'd3, 0, 0, 0);
      #2;
      chk("raw_stall",  32'(stall_id),  32'd1);
      chk("raw_bubble", 32'(bubble_ex), 32'd1);
      tick();
    end
    rd_reg(3'd3, 0, 0, 0);
    #2;
    chk("raw_release", 32'(stall_id),  32'd0);
    chk("raw_cnt",     32'(stall_cnt), 32'(NSTALL));
    tick();

    // Unused sources never stall.
    wr_reg(3'd3);
    drive(1, 3'd3, 0, 3'd3, 0, 0, 0, 0, 0, 0);
    #2;
    chk("unused_stall", 32'(stall_id), 32'd0);
    tick();
    #2;
    chk("unused_cnt", 32'(stall_cnt), 32'(NSTALL));
    idle(3);

    // Freeze in the middle of an R5 stall.
    base = NSTALL;
    wr_reg(3'd5);
    rd_reg(3'd5, 0, 0, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      rd_reg(3'd5, 1, 0, 0);
      #2;
      chk("frz_freeze", 32'(freeze),    32'd1);
      chk("frz_stall",  32'(stall_id),  32'd1);
      chk("frz_bubble", 32'(bubble_ex), 32'd0);
      chk("frz_pend",   32'(pend_vec),  32'h20);
      chk("frz_cnt",    32'(stall_cnt), 32'(base + 1));
      tick();
    end
    for (int i = 0; i < NSTALL - 1; i++) begin
      rd_reg(3'd5, 0, 0, 0);
      #2;
      chk("frz_resume", 32'(stall_id), 32'd1);
      tick();
    end
    rd_reg(3'd5, 0, 0, 0);
    #2;
    chk("frz_release", 32'(stall_id),  32'd0);
    chk("frz_total",   32'(stall_cnt), 32'(base + NSTALL));
    tick();
    idle(3);

    // Hit and flush in the same cycle: flush wins, nothing enters EX.
    base = base + NSTALL;
    wr_reg(3'd2);
    drive(1, 3'd2, 1, 3'd0, 0, 1, 3'd6, 0, 1, 0);
    #2;
    chk("fl_stall",  32'(stall_id),  32'd0);
    chk("fl_bubble", 32'(bubble_ex), 32'd1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("fl_pend", 32'(pend_vec),  32'h04);
    chk("fl_cnt",  32'(stall_cnt), 32'(base));
    tick();
    idle(3);

    // Reset during a frozen stall.
    wr_reg(3'd4);
    rd_reg(3'd4, 0, 0, 0);
    tick();
    rd_reg(3'd4, 1, 0, 1);
    #2;
    chk("rs_freeze", 32'(freeze), 32'd1);
    tick();
    rd_reg(3'd4, 0, 0, 0);
    #2;
    chk("rs_pend",  32'(pend_vec),  32'h00);
    chk("rs_cnt",   32'(stall_cnt), 32'd0);
    chk("rs_stall", 32'(stall_id),  32'd0);
    tick();
    idle(3);

    // Counter saturation from a preloaded 16'hFFFE.
    force_on = 1'b1;
    force dut.stall_cnt = 16'hFFFE;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    release dut.stall_cnt;
    force_on = 1'b0;
    #2;
    chk("sat_load", 32'(stall_cnt), 32'hFFFE);
    wr_reg(3'd1);
    rd_reg(3'd1, 0, 0, 0);
    tick();
    #2;
    chk("sat_first", 32'(stall_cnt), 32'hFFFF);
    tick();
    #2;
    chk("sat_hold", 32'(stall_cnt), 32'hFFFF);
    idle(4);
    chk("sat_final", 32'(stall_cnt), 32'hFFFF);

    // Random traffic over a narrow register range to provoke hazards.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom % 8) != 0, 3'($urandom % 4), 1'($urandom), 3'($urandom % 4), 1'($urandom),
            1'($urandom), 3'($urandom % 4), ($urandom % 10) == 0, ($urandom % 10) == 0,
            ($urandom % 200) == 0);
      tick();
    end
    idle(2);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
